accum_int_param: RTL and testbench

- Parametrised multi-lane integer accumulator. Each beat reduces LANES operands through a pipelined adder tree, then adds the beat sum into a running accumulator.
- A group is framed by explicit first/last flags and produces one result. Accumulation is explicit per instruction, never transparent.
- Adds signed/unsigned mode, saturate/wrap mode, lane masking, valid/ready handshakes and an overflow flag.
- Sits in the math unit beside the fixed-width accumulators and feeds the result writeback port.

---
 rtl/accum_int_param.sv | 214 +++++++++++++++++++++
 tb/tb_accum_int_param.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_int_param.sv
// accum_int_param: multi-lane integer accumulator with a pipelined adder tree.
// Groups are framed by first/last; one result per group with overflow flag.
module accum_int_param #(
    parameter int WIDTH = 64,
    parameter int LANES = 8,
    parameter int GUARD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]         in_lane_en,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic                     mode_signed,
    input  logic                     mode_sat,
    output logic [WIDTH+GUARD-1:0]   res,
    output logic                     res_ovf,
    output logic                     res_vld,
    input  logic                     res_rdy,
    output logic                     busy
);

    localparam int ACC_W = WIDTH + GUARD;
    localparam int S     = $clog2(LANES);

    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $fatal(1, "accum_int_param: LANES must be a power of 2, >= 2");
    end

    if (GUARD < $clog2(LANES)) begin : g_bad_guard
        $fatal(1, "accum_int_param: GUARD must be >= clog2(LANES)");
    end

    // input-side group tracking
    logic r_in_grp;
    logic r_mode_sgn;
    logic r_mode_sat;

    logic w_accept;
    logic w_first;
    logic w_sgn;
    logic w_sat;
    logic w_stall;

    // tree: heap of internal nodes, node 1 is the root (last stage)
    logic [ACC_W-1:0] w_ext  [LANES];
    logic [ACC_W-1:0] w_kid  [2:2*LANES-1];
    logic [ACC_W-1:0] r_node [1:LANES-1];

    logic [S:1] r_vld;
    logic [S:1] r_first;
    logic [S:1] r_last;
    logic [S:1] r_sgn;
    logic [S:1] r_sat;

    // accumulate stage
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_ovf;
    logic [ACC_W-1:0] r_res;
    logic             r_res_ovf;
    logic             r_res_vld;

    logic             w_top_vld;
    logic             w_top_first;
    logic             w_top_last;
    logic             w_top_sgn;
    logic             w_top_sat;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W:0]   w_wide;
    logic             w_ovf_now;
    logic [ACC_W-1:0] w_clamp;
    logic [ACC_W-1:0] w_acc_nx;
    logic             w_ovf_nx;
    logic             w_fire;

    assign w_top_vld   = r_vld[S];
    assign w_top_first = r_first[S];
    assign w_top_last  = r_last[S];
    assign w_top_sgn   = r_sgn[S];
    assign w_top_sat   = r_sat[S];
    assign w_sum       = r_node[1];

    // a held result blocks only a last beat that wants to overwrite it
    assign w_stall  = r_res_vld & ~res_rdy & w_top_vld & w_top_last;
    assign in_rdy   = rst & ~w_stall;
    assign w_accept = in_vld & in_rdy;
    assign w_fire   = w_top_vld & ~w_stall;

    // outside a group every beat opens one, whatever in_first says
    assign w_first = in_first | ~r_in_grp;
    assign w_sgn   = w_first ? mode_signed : r_mode_sgn;
    assign w_sat   = w_first ? mode_sat : r_mode_sat;

    assign res     = r_res;
    assign res_ovf = r_res_ovf;
    assign res_vld = r_res_vld;
    assign busy    = (|r_vld) | r_res_vld;

    // per-lane masking and sign/zero extension to the accumulator width
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_ext[k] = '0;
            if (in_lane_en[k]) begin
                w_ext[k] = {{GUARD{w_sgn & in_data[k*WIDTH+WIDTH-1]}},
                            in_data[k*WIDTH +: WIDTH]};
            end
        end
    end

    // children of every tree node: leaves are lanes, the rest are registers
    always_comb begin
        for (int n = LANES; n < 2 * LANES; n++) begin
            w_kid[n] = w_ext[n-LANES];
        end
        for (int n = 2; n < LANES; n++) begin
            w_kid[n] = r_node[n];
        end
    end

    // group state and modes latched on the effective first beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_grp   <= 1'b0;
            r_mode_sgn <= 1'b0;
            r_mode_sat <= 1'b0;
        end else if (w_accept) begin
            r_in_grp <= ~in_last;
            if (w_first) begin
                r_mode_sgn <= mode_signed;
                r_mode_sat <= mode_sat;
            end
        end
    end

    // adder tree stages with their sideband, all frozen on stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < LANES; i++) begin
                r_node[i] <= '0;
            end
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_sgn   <= '0;
            r_sat   <= '0;
        end else if (!w_stall) begin
            for (int i = 1; i < LANES; i++) begin
                r_node[i] <= w_kid[2*i] + w_kid[2*i+1];
            end
            r_vld[1]   <= w_accept;
            r_first[1] <= w_first;
            r_last[1]  <= in_last;
            r_sgn[1]   <= w_sgn;
            r_sat[1]   <= w_sat;
            for (int s = 2; s <= S; s++) begin
                r_vld[s]   <= r_vld[s-1];
                r_first[s] <= r_first[s-1];
                r_last[s]  <= r_last[s-1];
                r_sgn[s]   <= r_sgn[s-1];
                r_sat[s]   <= r_sat[s-1];
            end
        end
    end

    // one-bit-wider add detects overflow; clamp or wrap per group mode
    always_comb begin
        w_wide = {w_top_sgn & r_acc[ACC_W-1], r_acc}
               + {w_top_sgn & w_sum[ACC_W-1], w_sum};
        w_ovf_now = w_top_sgn ? (w_wide[ACC_W] ^ w_wide[ACC_W-1])
                              : w_wide[ACC_W];
        w_clamp = '1;
        if (w_top_sgn) begin
            w_clamp = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
        w_acc_nx = w_wide[ACC_W-1:0];
        w_ovf_nx = r_acc_ovf | w_ovf_now;
        if (w_top_first) begin
            w_acc_nx = w_sum;
            w_ovf_nx = 1'b0;
        end else if (w_ovf_now && w_top_sat) begin
            w_acc_nx = w_clamp;
        end
    end

    // running accumulator and sticky group overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_fire) begin
            r_acc     <= w_acc_nx;
            r_acc_ovf <= w_ovf_nx;
        end
    end

    // result register: loads on a last beat, held until the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res     <= '0;
            r_res_ovf <= 1'b0;
            r_res_vld <= 1'b0;
        end else if (w_fire && w_top_last) begin
            r_res     <= w_acc_nx;
            r_res_ovf <= w_ovf_nx;
            r_res_vld <= 1'b1;
        end else if (r_res_vld && res_rdy) begin
            r_res_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accum_int_param.sv
// tb_accum_int_param: directed and random checks of accum_int_param
// against an exact-integer reference model of group accumulation.
module tb_accum_int_param;

    localparam int W = 64;
    localparam int L = 8;
    localparam int G = 8;
    localparam int A = W + G;
    localparam int S = $clog2(L);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_vld;
    logic           in_rdy;
    logic [L*W-1:0] in_data;
    logic [L-1:0]   in_lane_en;
    logic           in_first;
    logic           in_last;
    logic           mode_signed;
    logic           mode_sat;
    logic [A-1:0]   res;
    logic           res_ovf;
    logic           res_vld;
    logic           res_rdy;
    logic           busy;

    accum_int_param #(.WIDTH(W), .LANES(L), .GUARD(G)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_data     (in_data),
        .in_lane_en  (in_lane_en),
        .in_first    (in_first),
        .in_last     (in_last),
        .mode_signed (mode_signed),
        .mode_sat    (mode_sat),
        .res         (res),
        .res_ovf     (res_ovf),
        .res_vld     (res_vld),
        .res_rdy     (res_rdy),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A-1:0] val;
        logic         ovf;
    } exp_t;

    exp_t                 exp_q[$];
    int                   checks = 0;
    int                   errors = 0;
    bit                   m_in_grp;
    bit                   m_sgn;
    bit                   m_sat;
    bit                   m_ovf;
    logic signed [127:0]  m_acc;
    bit                   rnd_rdy;
    bit                   popped;
    logic [A-1:0]         g_res;
    logic                 g_ovf;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // exact integer model of one accepted beat
    task automatic model_accept();
        logic signed [127:0] bs, ex, hi, lo, nx;
        logic [W-1:0]        lv;
        bit                  f;
        f = in_first || !m_in_grp;
        if (f) begin
            m_sgn = mode_signed;
            m_sat = mode_sat;
        end
        bs = 0;
        for (int k = 0; k < L; k++) begin
            if (in_lane_en[k]) begin
                lv = in_data[k*W +: W];
                if (m_sgn) bs = bs + {{(128-W){lv[W-1]}}, lv};
                else       bs = bs + {{(128-W){1'b0}}, lv};
            end
        end
        if (m_sgn) begin
            hi = (128'sd1 <<< (A-1)) - 1;
            lo = -(128'sd1 <<< (A-1));
        end else begin
            hi = (128'sd1 <<< A) - 1;
            lo = 0;
        end
        if (f) begin
            m_acc = bs;
            m_ovf = 0;
        end else begin
            ex = m_acc + bs;
            nx = ex;
            if (ex > hi || ex < lo) begin
                m_ovf = 1;
                if (m_sat) nx = (ex > hi) ? hi : lo;
                else nx = {{(128-A){m_sgn & ex[A-1]}}, ex[A-1:0]};
            end
            m_acc = nx;
        end
        if (in_last) exp_q.push_back('{m_acc[A-1:0], m_ovf});
        m_in_grp = !in_last;
    endtask

    // one clock: observe handshakes just before the edge, then advance
    task automatic step(output bit a);
        exp_t e;
        if (rnd_rdy) res_rdy = 1'($urandom_range(0, 1));
        #1;
        a = in_vld && in_rdy;
        if (res_vld && res_rdy) begin
            popped = 1;
            g_res  = res;
            g_ovf  = res_ovf;
            chk("res_expected", 128'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res", res, e.val);
                chk("res_ovf", res_ovf, e.ovf);
            end
        end
        if (a) model_accept();
        @(negedge clk);
    endtask

    task automatic send(input logic [L*W-1:0] d, input logic [L-1:0] en,
                        input bit f, input bit l, input bit sg,
                        input bit st);
        bit a;
        a           = 0;
        in_data     = d;
        in_lane_en  = en;
        in_first    = f;
        in_last     = l;
        mode_signed = sg;
        mode_sat    = st;
        in_vld      = 1;
        for (int n = 0; n < 200 && !a; n++) step(a);
        in_vld = 0;
        chk("accept_timeout", 128'(a), 1);
    endtask

    task automatic wait_vld(output int lat);
        bit a;
        lat = 1;
        while (!res_vld && lat <= 40) begin
            step(a);
            lat++;
        end
        chk("vld_timeout", res_vld, 1);
    endtask

    task automatic take_res();
        bit a;
        res_rdy = 1;
        popped  = 0;
        for (int i = 0; i < 50 && !popped; i++) step(a);
        res_rdy = 0;
        chk("take_timeout", 128'(popped), 1);
    endtask

    function automatic logic [L*W-1:0] rep(input logic [W-1:0] v);
        logic [L*W-1:0] d;
        for (int k = 0; k < L; k++) d[k*W +: W] = v;
        return d;
    endfunction

    function automatic logic [L*W-1:0] rnd_data();
        logic [L*W-1:0] d;
        for (int k = 0; k < L; k++) begin
            case ($urandom_range(0, 3))
                0: d[k*W +: W] = W'($urandom_range(0, 15));
                1: d[k*W +: W] = {$urandom, $urandom};
                2: d[k*W +: W] = 64'h7FFF_FFFF_FFFF_FFFF;
                default: d[k*W +: W] = 64'h8000_0000_0000_0000;
            endcase
        end
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit             a;
        int             lat;
        logic [L*W-1:0] d;
        logic [127:0]   wrapv;
        int             len;
        bit             sg, st, f;

        in_vld      = 0;
        in_data     = '0;
        in_lane_en  = '0;
        in_first    = 0;
        in_last     = 0;
        mode_signed = 0;
        mode_sat    = 0;
        res_rdy     = 0;
        rnd_rdy     = 0;
        m_in_grp    = 0;
        repeat (2) @(negedge clk);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_res", res, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_busy", busy, 0);
        rst = 1;
        #1;
        chk("rst_in_rdy", in_rdy, 1);
        @(negedge clk);

        // single beat, all ones, latency
        send(rep(1), 8'hFF, 1, 1, 0, 0);
        wait_vld(lat);
        chk("t1_latency", 128'(lat), S + 1);
        take_res();
        chk("t1_res", g_res, 8);
        chk("t1_ovf", g_ovf, 0);

        // three beats with a masked middle beat
        for (int k = 0; k < L; k++) d[k*W +: W] = W'(k + 1);
        send(d, 8'hFF, 1, 0, 0, 0);
        send(d, 8'h0F, 0, 0, 0, 0);
        send(d, 8'hFF, 0, 1, 0, 0);
        chk("t2_busy_hi", busy, 1);
        take_res();
        chk("t2_res", g_res, 82);
        chk("t2_busy_lo", busy, 0);

        // signed wrap
        d = rep(64'h7FFF_FFFF_FFFF_FFFF);
        send(d, 8'hFF, 1, 0, 1, 0);
        send(d, 8'hFF, 0, 1, 1, 0);
        take_res();
        chk("t3_fit_res", g_res, 72'h07_FFFF_FFFF_FFFF_FFF0);
        chk("t3_fit_ovf", g_ovf, 0);
        for (int i = 0; i < 300; i++) send(d, 8'hFF, i == 0, i == 299, 1, 0);
        take_res();
        wrapv = 128'd2400 * 128'h7FFF_FFFF_FFFF_FFFF;
        chk("t3_wrap_res", g_res, wrapv[A-1:0]);
        chk("t3_wrap_ovf", g_ovf, 1);

        // signed saturate, both bounds
        for (int i = 0; i < 300; i++) send(d, 8'hFF, i == 0, i == 299, 1, 1);
        take_res();
        chk("t4_max_res", g_res, 72'h7F_FFFF_FFFF_FFFF_FFFF);
        chk("t4_max_ovf", g_ovf, 1);
        d = rep(64'h8000_0000_0000_0000);
        for (int i = 0; i < 300; i++) send(d, 8'hFF, i == 0, i == 299, 1, 1);
        take_res();
        chk("t4_min_res", g_res, 72'h80_0000_0000_0000_0000);
        chk("t4_min_ovf", g_ovf, 1);

        // back-to-back groups with a stalled result
        send(rep(3), 8'hFF, 1, 1, 0, 0);
        send(rep(5), 8'hFF, 1, 1, 0, 0);
        wait_vld(lat);
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_rdy", in_rdy, 0);
            chk("t5_hold_res", res, 24);
            step(a);
        end
        take_res();
        chk("t5_first", g_res, 24);
        take_res();
        chk("t5_second", g_res, 40);
        chk("t5_q_empty", 128'(exp_q.size()), 0);

        // reset with a held result and beats in the tree
        send(rep(2), 8'hFF, 1, 1, 0, 0);
        wait_vld(lat);
        send(rep(9), 8'hFF, 1, 0, 0, 0);
        send(rep(9), 8'hFF, 0, 0, 0, 0);
        rst = 0;
        #1;
        chk("t6_res_vld", res_vld, 0);
        chk("t6_res", res, 0);
        chk("t6_res_ovf", res_ovf, 0);
        chk("t6_busy", busy, 0);
        exp_q.delete();
        m_in_grp = 0;
        @(negedge clk);
        rst = 1;
        step(a);
        chk("t6_rdy", in_rdy, 1);
        send(rep(4), 8'hFF, 0, 0, 0, 0);
        send(rep(1), 8'h01, 0, 1, 0, 0);
        take_res();
        chk("t6_res_after", g_res, 33);

        // random groups, restarts, modes and back-pressure
        rnd_rdy = 1;
        for (int g = 0; g < 80; g++) begin
            len = $urandom_range(1, 5);
            sg  = 1'($urandom_range(0, 1));
            st  = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                if (b == 0) f = ($urandom_range(0, 3) != 0);
                else        f = ($urandom_range(0, 9) == 0);
                send(rnd_data(), 8'($urandom), f, b == len - 1,
                     f ? sg : 1'($urandom_range(0, 1)),
                     f ? st : 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 1)) step(a);
            end
        end
        rnd_rdy = 0;
        res_rdy = 1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(a);
        repeat (S + 2) step(a);
        chk("drain_empty", 128'(exp_q.size()), 0);
        chk("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
